// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI slave responder.
package spi_slave_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int         DATA_W_DEF    = 8;
    localparam logic [7:0] IDLE_FILL_DEF = 8'hFF;
    localparam int         RX_FIFO_DEPTH = 4;
endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one SPI pin, with rise/fall detection on the synchronized level.
module spi_slave_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            sync_reg[0] <= din;
            prev_reg    <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;
endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI slave with TX/RX valid-ready byte interfaces.
// Define SPI_SLAVE_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module spi_slave_responder
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = IDLE_FILL_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              frame_err
);
    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic ss_level, ss_rise, ss_fall;
    logic unused_sync;

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk_clk), .rst(reset_reset), .din(spi_sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
    spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk_clk), .rst(reset_reset), .din(spi_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));
    spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk_clk), .rst(reset_reset), .din(spi_ss_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall));

    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall, ss_level};

    state_t            state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] tx_shift_reg, rx_shift_reg, tx_hold_reg;
    logic              tx_full_reg, fill_pending_reg;
    logic              tx_underrun_reg, frame_err_reg, rx_overrun_reg;

    // Underrun is only reported once the fill byte actually goes on the wire,
    // so the speculative reload after a frame's last byte stays silent.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= '0;
            tx_shift_reg     <= '0;
            rx_shift_reg     <= '0;
            tx_hold_reg      <= '0;
            tx_full_reg      <= 1'b0;
            fill_pending_reg <= 1'b0;
            tx_underrun_reg  <= 1'b0;
            frame_err_reg    <= 1'b0;
        end else begin
            tx_underrun_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            if (tx_valid && !tx_full_reg) begin
                tx_hold_reg <= tx_data;
                tx_full_reg <= 1'b1;
            end
            if (ss_rise) begin
                state_reg        <= ST_IDLE;
                frame_err_reg    <= (bit_cnt_reg != '0);
                bit_cnt_reg      <= '0;
                rx_shift_reg     <= '0;
                fill_pending_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (ss_fall) state_reg <= ST_LOAD;
                    end
                    ST_LOAD, ST_DONE: begin
                        state_reg <= ST_SHIFT;
                        if (tx_full_reg) begin
                            tx_shift_reg     <= tx_hold_reg;
                            tx_full_reg      <= 1'b0;
                            fill_pending_reg <= 1'b0;
                        end else begin
                            tx_shift_reg     <= IDLE_FILL;
                            fill_pending_reg <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (sclk_rise) begin
                            rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_level};
                            if (bit_cnt_reg == '0 && fill_pending_reg) begin
                                tx_underrun_reg  <= 1'b1;
                                fill_pending_reg <= 1'b0;
                            end
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_DONE;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else if (sclk_fall && bit_cnt_reg != '0) begin
                            // The trailing fall of the previous byte arrives with count 0 and must not shift out the fresh MSB.
                            tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi_miso    = tx_shift_reg[DATA_W-1];
    assign spi_miso_oe = (state_reg != ST_IDLE);
    assign tx_ready    = ~tx_full_reg;
    assign tx_underrun = tx_underrun_reg;
    assign frame_err   = frame_err_reg;
    assign rx_overrun  = rx_overrun_reg;

    logic rx_wr, rx_pop;
    assign rx_wr  = (state_reg == ST_DONE);
    assign rx_pop = rx_valid && rx_ready;

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int               PTR_W     = $clog2(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(RX_FIFO_DEPTH);
    logic [DATA_W-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              rx_full, rx_push;

    assign rx_full = (count_reg == DEPTH_CNT) && !rx_pop;
    assign rx_push = rx_wr && !rx_full;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            rx_overrun_reg <= 1'b0;
        end else begin
            rx_overrun_reg <= rx_wr && rx_full;
            if (rx_push) begin
                fifo_mem[wr_ptr_reg] <= rx_shift_reg;
                wr_ptr_reg           <= wr_ptr_reg + 1'b1;
            end
            if (rx_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rx_data  = fifo_mem[rd_ptr_reg];
    assign rx_valid = (count_reg != '0);
`else
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg;
    logic              rx_full;

    assign rx_full = rx_valid_reg && !rx_ready;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
        end else begin
            rx_overrun_reg <= rx_wr && rx_full;
            if (rx_wr && !rx_full) begin
                rx_data_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_pop) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
`endif
endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 8: SPI frame width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for spi_sclk, spi_mosi and spi_ss_n.
REQ-003 SHALL have parameter IDLE_FILL, default 8'hFF: byte shifted out on MISO when no TX byte is pending.
REQ-004 SHALL have port clk_clk, input, 1: the single system clock, frequency at least 8x SCLK.
REQ-005 SHALL have port reset_reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports spi_sclk, spi_mosi, spi_ss_n, each input, 1: SPI from the HPS SPI master, mode 0, MSB first.
REQ-007 SHALL have ports spi_miso, output, 1, and spi_miso_oe, output, 1: serial data and its drive enable.
REQ-008 SHALL have ports tx_data, input, DATA_W; tx_valid, input, 1; tx_ready, output, 1: TX byte valid/ready handshake.
REQ-009 SHALL have ports rx_data, output, DATA_W; rx_valid, output, 1; rx_ready, input, 1: RX byte valid/ready handshake.
REQ-010 SHALL have ports rx_overrun, tx_underrun and frame_err, each output, 1: single-cycle status pulses.

Function
REQ-011 SHALL pass the three SPI inputs through SYNC_STAGES flops, then detect SCLK rise and fall and SS_n fall and rise on the synchronized signals.
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT and DONE.
REQ-013 IDLE -> LOAD on SS_n fall; LOAD -> SHIFT after 1 cycle; SHIFT -> DONE on the DATA_W-th SCLK rise; DONE -> SHIFT after 1 cycle while SS_n is low; any state -> IDLE on SS_n rise.
REQ-014 LOAD and DONE SHALL load the TX shift register with the pending TX byte (tx_ready=1 in that cycle) or with IDLE_FILL if none is pending (tx_underrun pulse in that case).
REQ-015 tx_ready SHALL be 1 whenever the one-entry TX holding register is empty; a byte is accepted on tx_valid&tx_ready.
REQ-016 SHALL sample MOSI into the RX shift register on each SCLK rise and shift MISO to the next bit on each SCLK fall; spi_miso SHALL equal the TX shift register MSB.
REQ-017 spi_miso_oe SHALL be 1 only while the FSM is not in IDLE.
REQ-018 In DONE the completed byte SHALL be written to RX storage, so that rx_valid rises 1 cycle after the sync-detected final SCLK rise.
REQ-019 If RX storage is full in DONE, the new byte SHALL be dropped, the stored data left unchanged and rx_overrun pulsed.
REQ-020 RX storage SHALL release a byte on rx_valid&rx_ready; a read and a write in the same cycle SHALL both take effect.
REQ-021 SS_n rise with a bit count of 1 to DATA_W-1 SHALL discard the partial byte, pulse frame_err and clear the bit counter; the TX holding register SHALL be preserved.
REQ-022 The bit counter SHALL wrap to 0 after DATA_W bits so that back-to-back bytes run within one SS_n assertion.

Reset
REQ-023 Reset SHALL clear all state asynchronously: FSM=IDLE, counters=0, holding registers empty, synchronizers to idle levels (sclk=0, ss_n=1).
REQ-024 Output reset values SHALL be spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, and all status pulses 0.
REQ-025 Reset during a frame SHALL abort the frame; after reset is released the block waits for a fresh SS_n fall.

Configuration
REQ-026 Macro SPI_SLAVE_RX_FIFO_EN defined: RX storage SHALL be a 4-entry FIFO, with rx_data showing the head entry and rx_valid meaning not empty.
REQ-027 Macro SPI_SLAVE_RX_FIFO_EN undefined: RX storage SHALL be a one-entry holding register; full means rx_valid=1.

Structure
REQ-028 Package spi_slave_pkg SHALL hold the FSM state enum, DATA_W_DEF, IDLE_FILL_DEF and RX_FIFO_DEPTH (=4).
REQ-029 Sub-module spi_slave_sync SHALL implement the parameterized synchronizer plus edge detector and be instantiated once per SPI input.

Verification
REQ-030 tx_data=0x3C is loaded, then the master sends 0xA5 -> MISO carries 0x3C, rx_data=0xA5 with one rx_valid handshake, and tx_underrun stays 0.
REQ-031 No TX byte is loaded and the master sends 0x00 -> MISO carries 0xFF, tx_underrun pulses once, and rx_data=0x00.
REQ-032 rx_ready is held 0 and two bytes 0x11, 0x22 are sent (FIFO off) -> rx_data stays 0x11 and rx_overrun pulses once; with FIFO on, five bytes are sent -> the first four are held and read in order, and rx_overrun pulses on the fifth.
REQ-033 SS_n rises after 5 bits -> frame_err pulses, rx_valid does not rise, and the next full byte 0x5A is received correctly.
REQ-034 reset_reset is asserted after 3 bits -> outputs show reset values at once, and after release a full frame 0xC3 is received correctly.
REQ-035 Two bytes 0x01, 0x02 are sent back-to-back under one SS_n with TX 0x80, 0x40 preloaded in turn -> both RX bytes are delivered in order and MISO carries 0x80 then 0x40.
